// File: rtl/run_step_ctrl_if.sv
// Signal bundle between the run/step controller, the system/debug side and DATA_PATH.
// The controller sits on the slave modport; the debug side / bench drives the master modport.
interface run_step_ctrl_if #(
  parameter int PC_W   = 12,
  parameter int INST_W = 16,
  parameter int CNT_W  = 16
) ();

  // Debug / system side requests
  logic              start;
  logic              mode;
  logic              step;
  logic              abort;
  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;

  // DATA_PATH observation
  logic [PC_W-1:0]   pc_in;
  logic [INST_W-1:0] inst_in;

  // Controller outputs
  logic              go;
  logic              run_en;
  logic              busy;
  logic              done;
  logic [2:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, mode, step, abort, bp_en, bp_addr, pc_in, inst_in,
    input  go, run_en, busy, done, halt_cause, cycle_count
  );

  modport slave (
    input  start, mode, step, abort, bp_en, bp_addr, pc_in, inst_in,
    output go, run_en, busy, done, halt_cause, cycle_count
  );

endinterface

// File: rtl/run_step_ctrl.sv
// Run/step controller for DATA_PATH: launches a run with a go pulse, gates the
// datapath clock enable in free-run or single-step mode, and stops on halt/bp/timeout/abort.
module run_step_ctrl #(
  parameter int                PC_W      = 12,
  parameter int                INST_W    = 16,
  parameter int                CNT_W     = 16,
  parameter int                GO_CYCLES = 1,
  parameter logic [INST_W-1:0] HALT_INST = 16'hF000,
  parameter int                TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  run_step_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_STEP,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    C_NONE    = 3'd0,
    C_HALT    = 3'd1,
    C_BP      = 3'd2,
    C_TIMEOUT = 3'd3,
    C_ABORT   = 3'd4
  } cause_e;

  localparam int               GO_W     = (GO_CYCLES > 1) ? $clog2(GO_CYCLES) : 1;
  localparam logic [GO_W-1:0]  GO_LAST  = GO_W'(GO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [GO_W-1:0]  go_cnt_q, go_cnt_d;
  logic             step_q;
  logic             step_fire_q, step_fire_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             run_en;
  logic             step_edge;
  logic             stop_hit;
  cause_e           stop_cause;
  logic [PC_W-1:0]  pc_cur;
  logic [PC_W-1:0]  bp_pc;

  assign pc_cur    = bus.pc_in;
  assign bp_pc     = bus.bp_addr;
  assign step_edge = bus.step & ~step_q;

  // run_en is a decode of state plus a registered step strobe, so no input reaches it combinationally.
  assign run_en = (state_q == S_RUN) || step_fire_q;

  // Stop priority: halt instruction, then breakpoint, then timeout.
  always_comb begin
    stop_hit   = 1'b1;
    stop_cause = C_NONE;
    if (bus.inst_in == HALT_INST) begin
      stop_cause = C_HALT;
    end else if (bus.bp_en && (pc_cur == bp_pc)) begin
      stop_cause = C_BP;
    end else if ((TIMEOUT != 0) && (count_q == TO_LAST)) begin
      stop_cause = C_TIMEOUT;
    end else begin
      stop_hit = 1'b0;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    go_cnt_d    = go_cnt_q;
    step_fire_d = 1'b0;
    cause_d     = cause_q;
    count_d     = count_q;

    if (run_en && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_LAUNCH;
          go_cnt_d = '0;
          cause_d  = C_NONE;
          count_d  = '0;
        end
      end

      S_LAUNCH: begin
        if (bus.abort) begin
          state_d = S_DONE;
          cause_d = C_ABORT;
        end else if (go_cnt_q == GO_LAST) begin
          state_d = bus.mode ? S_STEP : S_RUN;
        end else begin
          go_cnt_d = go_cnt_q + GO_W'(1);
        end
      end

      S_RUN, S_STEP: begin
        if (bus.abort) begin
          state_d = S_DONE;
          cause_d = C_ABORT;
        end else if (run_en && stop_hit) begin
          state_d = S_DONE;
          cause_d = stop_cause;
        end else if ((state_q == S_STEP) && step_edge) begin
          step_fire_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      go_cnt_q    <= '0;
      step_q      <= 1'b0;
      step_fire_q <= 1'b0;
      cause_q     <= C_NONE;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      go_cnt_q    <= go_cnt_d;
      step_q      <= bus.step;
      step_fire_q <= step_fire_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
    end
  end

  assign bus.go          = (state_q == S_LAUNCH);
  assign bus.run_en      = run_en;
  assign bus.busy        = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_STEP);
  assign bus.done        = (state_q == S_DONE);
  assign bus.halt_cause  = cause_q;
  assign bus.cycle_count = count_q;

endmodule
